reset_sequencer: RTL and testbench

//   Parametrised successor to the single-output reset synchroniser. Synchronises one

---
 rtl/reset_sequencer_pkg.sv | 16 +
 rtl/reset_sequencer_if.sv | 17 +
 rtl/reset_sequencer_sync_chain.sv | 23 ++
 rtl/reset_sequencer.sv | 128 ++++++++++++
 tb/tb_reset_sequencer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the width helper used to size its counters.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_STRETCH = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle of the reset sequencer: the re-sequence request in,
// the sequenced resets, the done flag and the FSM state out.
interface reset_sequencer_if
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_OUTS = 4
);
  // sw_rst_req is a one-cycle request pulse with no acknowledge. It is acted
  // on only while dbg_state == S_DONE and is otherwise dropped.
  logic                sw_rst_req;
  logic [NUM_OUTS-1:0] rst_n;
  logic                rst_done;
  state_t              dbg_state;

  modport master (output sw_rst_req, input rst_n, rst_done, dbg_state);
  modport slave  (input sw_rst_req, output rst_n, rst_done, dbg_state);
endinterface

// File: rtl/reset_sequencer_sync_chain.sv
// Reset synchroniser: asserts asynchronously and deasserts after SYNC_STAGES
// rising edges.
module reset_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_async_n,
  output logic sync_q
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises rst_async_n, stretches it, then releases
// NUM_OUTS reset domains in index order, GAP_CYCLES apart.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int NUM_OUTS        = 4,
  parameter int STRETCH_CYCLES  = 16,
  parameter int GAP_CYCLES      = 4,
  parameter bit NEGEDGE_RELEASE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_async_n,
  reset_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, GAP_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_OUTS + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_OUTS-1:0] rel_q, rel_d;
  logic                done_q, done_d;
  logic                sync_q;

  reset_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .sync_q      (sync_q)
  );

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    done_d  = done_q;
    case (state_q)
      S_RESET: begin
        rel_d  = '0;
        done_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (sync_q) begin
          state_d = S_STRETCH;
          cnt_d   = CNT_W'(1);
        end
      end
      S_STRETCH: begin
        if (cnt_q == CNT_W'(STRETCH_CYCLES)) begin
          rel_d[0] = 1'b1;
          cnt_d    = CNT_W'(1);
          idx_d    = IDX_W'(1);
          if (NUM_OUTS == 1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (cnt_q == CNT_W'(GAP_CYCLES)) begin
          for (int i = 0; i < NUM_OUTS; i++) begin
            if (IDX_W'(i) == idx_q) rel_d[i] = 1'b1;
          end
          idx_d = idx_q + IDX_W'(1);
          cnt_d = CNT_W'(1);
          // done rises on the same edge as the last release bit
          if (idx_q == IDX_W'(NUM_OUTS - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (bus.sw_rst_req) begin
          rel_d   = '0;
          done_d  = 1'b0;
          cnt_d   = CNT_W'(1);
          idx_d   = '0;
          state_d = S_STRETCH;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // Negedge retiming moves both release and sw-driven assertion half a cycle later.
  generate
    if (NEGEDGE_RELEASE) begin : g_neg_out
      logic [NUM_OUTS-1:0] rst_n_q;
      always_ff @(negedge clk or negedge rst_async_n) begin
        if (!rst_async_n) rst_n_q <= '0;
        else              rst_n_q <= rel_q;
      end
      assign bus.rst_n = rst_n_q;
    end else begin : g_pos_out
      assign bus.rst_n = rel_q;
    end
  endgenerate

  assign bus.rst_done  = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default negedge config, a single-output
// posedge config with STRETCH_CYCLES=1, and a SYNC_STAGES=3 config.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  logic clk;
  logic rst_async_n;
  int   checks;
  int   errors;

  reset_sequencer_if #(.NUM_OUTS(4)) a_if ();
  reset_sequencer_if #(.NUM_OUTS(1)) b_if ();
  reset_sequencer_if #(.NUM_OUTS(4)) c_if ();

  reset_sequencer #(
    .SYNC_STAGES(2), .NUM_OUTS(4), .STRETCH_CYCLES(16), .GAP_CYCLES(4), .NEGEDGE_RELEASE(1'b1)
  ) u_dut_a (.clk(clk), .rst_async_n(rst_async_n), .bus(a_if.slave));

  reset_sequencer #(
    .SYNC_STAGES(2), .NUM_OUTS(1), .STRETCH_CYCLES(1), .GAP_CYCLES(4), .NEGEDGE_RELEASE(1'b0)
  ) u_dut_b (.clk(clk), .rst_async_n(rst_async_n), .bus(b_if.slave));

  reset_sequencer #(
    .SYNC_STAGES(3), .NUM_OUTS(4), .STRETCH_CYCLES(16), .GAP_CYCLES(4), .NEGEDGE_RELEASE(1'b0)
  ) u_dut_c (.clk(clk), .rst_async_n(rst_async_n), .bus(c_if.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Number of outputs released by posedge n, given T0 and the timing parameters.
  function automatic int n_rel(input int n, input int t0, input int s, input int g, input int num);
    int c = 0;
    for (int i = 0; i < num; i++) if (n >= t0 + s + i * g) c++;
    return c;
  endfunction

  function automatic logic [31:0] mask(input int c);
    return (32'd1 << c) - 32'd1;
  endfunction

  // Default config, release at posedge 3 (T0): state after posedge n.
  function automatic state_t exp_state_a(input int n);
    if (n < 3)  return S_RESET;
    if (n < 19) return S_STRETCH;
    if (n < 31) return S_RELEASE;
    return S_DONE;
  endfunction

  // Called just after rst_async_n rises between a negedge and the next posedge.
  task automatic run_seq(input int n_max);
    for (int n = 1; n <= n_max; n++) begin
      @(posedge clk); #1;
      check("a_done",      32'(a_if.rst_done),  32'(n >= 31));
      check("a_rst_n_pos", 32'(a_if.rst_n),     mask(n_rel(n - 1, 3, 16, 4, 4)));
      check("a_state",     32'(a_if.dbg_state), 32'(exp_state_a(n)));
      check("b_rst_n",     32'(b_if.rst_n),     mask(n_rel(n, 3, 1, 4, 1)));
      check("b_done",      32'(b_if.rst_done),  32'(n >= 4));
      check("c_rst_n",     32'(c_if.rst_n),     mask(n_rel(n, 4, 16, 4, 4)));
      check("c_done",      32'(c_if.rst_done),  32'(n >= 32));
      @(negedge clk); #1;
      check("a_rst_n_neg", 32'(a_if.rst_n),     mask(n_rel(n, 3, 16, 4, 4)));
    end
  endtask

  // Driver: one-cycle sw_rst_req in DONE, then follow the re-release of config A.
  task automatic sw_seq(input int m_max, input bit mid_pulse);
    @(negedge clk); #2;
    a_if.sw_rst_req = 1'b1;
    @(posedge clk); #1;
    a_if.sw_rst_req = 1'b0;
    check("sw_done_clr",  32'(a_if.rst_done),  32'd0);
    check("sw_state",     32'(a_if.dbg_state), 32'(S_STRETCH));
    check("sw_rst_n_pos", 32'(a_if.rst_n),     32'hf);
    @(negedge clk); #1;
    check("sw_rst_n_neg", 32'(a_if.rst_n),     32'h0);
    for (int m = 1; m <= m_max; m++) begin
      @(posedge clk); #1;
      if (m == 18) a_if.sw_rst_req = 1'b0;
      check("sw_done",   32'(a_if.rst_done), 32'(m >= 28));
      check("sw_rst_np", 32'(a_if.rst_n),    mask(n_rel(m - 1, 0, 16, 4, 4)));
      if (mid_pulse && m == 17) a_if.sw_rst_req = 1'b1;
      @(negedge clk); #1;
      check("sw_rst_nn", 32'(a_if.rst_n),    mask(n_rel(m, 0, 16, 4, 4)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_async_n = 1'b0;
    a_if.sw_rst_req = 1'b0;
    b_if.sw_rst_req = 1'b0;
    c_if.sw_rst_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_a_rst_n", 32'(a_if.rst_n),     32'h0);
    check("rst_a_done",  32'(a_if.rst_done),  32'd0);
    check("rst_a_state", 32'(a_if.dbg_state), 32'(S_RESET));
    check("rst_b_rst_n", 32'(b_if.rst_n),     32'h0);
    check("rst_c_rst_n", 32'(c_if.rst_n),     32'h0);

    // Initial release of all three configurations
    @(negedge clk); #2;
    rst_async_n = 1'b1;
    run_seq(36);

    // Software re-sequence, with an ignored pulse during S_RELEASE
    sw_seq(30, 1'b1);

    // Re-sequence again, then async reset mid-gap with rst_n = 0011
    sw_seq(22, 1'b0);
    #2;
    rst_async_n = 1'b0;
    #1;
    check("mid_a_rst_n", 32'(a_if.rst_n),     32'h0);
    check("mid_a_done",  32'(a_if.rst_done),  32'd0);
    check("mid_a_state", 32'(a_if.dbg_state), 32'(S_RESET));
    check("mid_b_rst_n", 32'(b_if.rst_n),     32'h0);
    check("mid_c_done",  32'(c_if.rst_done),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_async_n = 1'b1;
    run_seq(36);

    // Sub-cycle glitch on rst_async_n
    @(negedge clk); #1;
    rst_async_n = 1'b0;
    #1;
    check("gl_a_rst_n", 32'(a_if.rst_n),    32'h0);
    check("gl_a_done",  32'(a_if.rst_done), 32'd0);
    check("gl_b_rst_n", 32'(b_if.rst_n),    32'h0);
    check("gl_b_done",  32'(b_if.rst_done), 32'd0);
    check("gl_c_rst_n", 32'(c_if.rst_n),    32'h0);
    #2;
    rst_async_n = 1'b1;
    run_seq(36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
